// File: rtl/grf_writeback.sv
`default_nettype none
// ============================================================================
//  Module   : grf_writeback
//  Brief    : General register file for the single-cycle MIPS datapath.
//             2^DEPTH_LOG2 x WIDTH registers, two combinational read ports,
//             one synchronous write port, register $0 hardwired to zero.
//             Every committed write prints a checker-format trace line.
//  Options  : define GRF_BYPASS_EN to forward same-cycle write data to the
//             read ports (write-to-read bypass).
//  Revision : 1.0 - initial release
// ============================================================================
module grf_writeback #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 5,
  parameter bit TRACE_ON   = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           PC,
  input  logic [DEPTH_LOG2-1:0] A1,
  input  logic [DEPTH_LOG2-1:0] A2,
  input  logic [DEPTH_LOG2-1:0] A3,
  input  logic [WIDTH-1:0]      WD,
  input  logic                  RegWrite,
  output logic [WIDTH-1:0]      RD1,
  output logic [WIDTH-1:0]      RD2
);

  localparam int c_DEPTH = 1 << DEPTH_LOG2;

  // Storage. Entry 0 is only ever cleared; reads of $0 are forced to zero.
  logic [WIDTH-1:0] r_regs [c_DEPTH];

  // One write-enable per writable register. Gating by RegWrite first keeps
  // an unknown A3 from producing any enable while writes are off.
  logic [c_DEPTH-1:1] w_we;

  generate
    for (genvar gi = 1; gi < c_DEPTH; gi++) begin : g_dec
      assign w_we[gi] = RegWrite && (A3 == DEPTH_LOG2'(gi));
    end
  endgenerate

  // Register update: reset clears everything and wins over a pending write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < c_DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      for (int i = 1; i < c_DEPTH; i++) begin
        if (w_we[i]) begin
          r_regs[i] <= WD;
        end
      end
    end
  end

  // Array read with $0 forced to zero.
  logic [WIDTH-1:0] w_arr1;
  logic [WIDTH-1:0] w_arr2;

  // Array read ports.
  always_comb begin
    w_arr1 = (A1 == '0) ? '0 : r_regs[A1];
    w_arr2 = (A2 == '0) ? '0 : r_regs[A2];
  end

  logic w_byp1;
  logic w_byp2;

`ifdef GRF_BYPASS_EN
  // Forward the in-flight write; never for $0 and never while in reset.
  always_comb begin
    w_byp1 = !reset && RegWrite && (A3 != '0) && (A3 == A1);
    w_byp2 = !reset && RegWrite && (A3 != '0) && (A3 == A2);
  end
`else
  // No forwarding: same-cycle reads observe the pre-write contents.
  always_comb begin
    w_byp1 = 1'b0;
    w_byp2 = 1'b0;
  end
`endif

  // Final read data selection.
  always_comb begin
    RD1 = w_byp1 ? WD : w_arr1;
    RD2 = w_byp2 ? WD : w_arr2;
  end

`ifndef SYNTHESIS
  // Checker trace: shows the requested write, including writes aimed at $0.
  always_ff @(posedge clk) begin
    if (TRACE_ON && !reset && RegWrite) begin
      $display("@%h: $%d <= %h", PC, A3, WD);
    end
  end
`endif

endmodule
`default_nettype wire
